// File: rtl/hazard_unit_sb.sv
// Hazard controller: forwarding, load-use, PC flush and multicycle scoreboard.
// Define HAZ_PERF_CNT_EN to add saturating stall_cnt / flush_cnt outputs.
module hazard_unit_sb #(
    parameter int RA_W   = 4,
    parameter int NSRC   = 3,
    parameter int MC_LAT = 4,
    parameter int PC_IDX = 15
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NSRC*RA_W-1:0] ra_d,
    input  logic [NSRC-1:0]      src_vld_d,
    input  logic [NSRC*RA_W-1:0] ra_e,
    input  logic [NSRC-1:0]      src_vld_e,
    input  logic [RA_W-1:0]      wa3_e,
    input  logic [RA_W-1:0]      wa3_m,
    input  logic [RA_W-1:0]      wa3_w,
    input  logic                 regwrite_e,
    input  logic                 regwrite_m,
    input  logic                 regwrite_w,
    input  logic                 memtoreg_e,
    input  logic                 mc_start_d,
    input  logic                 mc_start_e,
    input  logic                 pcsrc_d,
    input  logic                 pcsrc_e,
    input  logic                 pcsrc_m,
    input  logic                 pcsrc_w,
    input  logic                 branch_taken_e,
    output logic [2*NSRC-1:0]    fwd_e,
    output logic                 stall_f,
    output logic                 stall_d,
    output logic                 flush_d,
    output logic                 flush_e,
    output logic                 mc_busy,
    output logic                 mc_done
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]          stall_cnt,
    output logic [31:0]          flush_cnt
`endif
);

    localparam int             NREG   = 1 << RA_W;
    localparam logic [RA_W-1:0] LP_PC  = RA_W'(PC_IDX);
    localparam logic [3:0]      LP_CNT = 4'(MC_LAT - 1);

    logic [NREG-1:0]   r_pending;
    logic [3:0]        r_cnt;
    logic              r_busy;
    logic              r_done;
    logic [RA_W-1:0]   r_dest;

    logic [2*NSRC-1:0] w_fwd;
    logic              w_ldr;
    logic              w_sb;
    logic              w_struct;
    logic              w_hz;
    logic              w_pcwr;

    always_comb begin
        w_fwd = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_vld_e[i] && ra_e[i*RA_W +: RA_W] != LP_PC) begin
                if (regwrite_m && wa3_m == ra_e[i*RA_W +: RA_W])
                    w_fwd[2*i +: 2] = 2'b10;
                else if (regwrite_w && wa3_w == ra_e[i*RA_W +: RA_W])
                    w_fwd[2*i +: 2] = 2'b01;
            end
        end
    end

    // Issue-cycle term covers the RAW before the pending bit lands.
    always_comb begin
        w_ldr = 1'b0;
        w_sb  = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (src_vld_d[i]) begin
                if (memtoreg_e && regwrite_e &&
                    ra_d[i*RA_W +: RA_W] == wa3_e)
                    w_ldr = 1'b1;
                if (r_pending[ra_d[i*RA_W +: RA_W]])
                    w_sb = 1'b1;
                if (mc_start_e && regwrite_e &&
                    ra_d[i*RA_W +: RA_W] == wa3_e)
                    w_sb = 1'b1;
            end
        end
    end

    assign w_struct = mc_start_d && (r_busy || mc_start_e);
    assign w_hz     = w_ldr | w_sb | w_struct;
    assign w_pcwr   = pcsrc_d | pcsrc_e | pcsrc_m;

    assign fwd_e   = w_fwd;
    assign stall_d = w_hz;
    assign stall_f = w_hz | w_pcwr;
    assign flush_d = w_pcwr | pcsrc_w | branch_taken_e;
    assign flush_e = w_hz | branch_taken_e;
    assign mc_busy = r_busy;
    assign mc_done = r_done;

    // Flushes never touch this state: the in-flight op is older.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_dest    <= '0;
        end else if (r_busy) begin
            if (r_done) begin
                r_busy            <= 1'b0;
                r_done            <= 1'b0;
                r_pending[r_dest] <= 1'b0;
            end else begin
                r_cnt  <= r_cnt - 4'd1;
                r_done <= (r_cnt == 4'd1);
            end
        end else if (mc_start_e) begin
            r_busy <= 1'b1;
            r_cnt  <= LP_CNT;
            r_dest <= wa3_e;
            if (regwrite_e && wa3_e != LP_PC)
                r_pending[wa3_e] <= 1'b1;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (stall_d && r_stall_cnt != 32'hFFFF_FFFF)
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if ((flush_d | flush_e) && r_flush_cnt != 32'hFFFF_FFFF)
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`endif

endmodule
